// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: tracks in-flight register writes in a 3-entry scoreboard
// and produces PC/IF-ID enables, ID/EXE bubble and fetch squash for stalls and taken branches.
module hazard_stall_ctrl #(
    parameter int unsigned ASIZE = 5,
    parameter int unsigned CSIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [ASIZE-1:0] id_raddr1,
    input  logic [ASIZE-1:0] id_raddr2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_wen,
    input  logic [ASIZE-1:0] id_waddr,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_bubble,
    output logic             flush_if,
    output logic [1:0]       state,
    output logic [CSIZE-1:0] stall_count,
    output logic [CSIZE-1:0] flush_count
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StFlush = 2'b10
    } state_e;

    state_e state_q, state_d;

    // Entry 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]       sb_valid_q, sb_valid_d;
    logic [ASIZE-1:0] sb_waddr_q [3];
    logic [ASIZE-1:0] sb_waddr_d [3];

    logic [CSIZE-1:0] stall_count_q, stall_count_d;
    logic [CSIZE-1:0] flush_count_q, flush_count_d;

    logic raw_match;
    logic hazard;
    logic issue;
    logic stall_inc;
    logic flush_inc;

    // WB entries still count: the register file is written at the edge, not bypassed.
    always_comb begin
        raw_match = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sb_valid_q[i] && (sb_waddr_q[i] != '0)) begin
                if (id_use1 && (id_raddr1 == sb_waddr_q[i])) raw_match = 1'b1;
                if (id_use2 && (id_raddr2 == sb_waddr_q[i])) raw_match = 1'b1;
            end
        end
        hazard = id_valid & raw_match;
    end

    always_comb begin
        state_d     = StRun;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_bubble = 1'b0;
        flush_if    = 1'b0;
        issue       = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (state_q == StFlush) begin
            // A branch here is impossible: EXE holds a bubble.
            idex_bubble = 1'b1;
            flush_if    = 1'b1;
        end else if (ex_branch_taken) begin
            idex_bubble = 1'b1;
            flush_if    = 1'b1;
            state_d     = StFlush;
            flush_inc   = 1'b1;
        end else if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = StStall;
            stall_inc   = 1'b1;
        end else begin
            issue = id_valid;
        end

        if (rst) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_bubble = 1'b0;
            flush_if    = 1'b0;
        end
    end

    always_comb begin
        sb_valid_d    = {sb_valid_q[1:0], issue & id_wen};
        sb_waddr_d[0] = issue ? id_waddr : '0;
        sb_waddr_d[1] = sb_waddr_q[0];
        sb_waddr_d[2] = sb_waddr_q[1];

        stall_count_d = stall_count_q;
        if (stall_inc && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
        flush_count_d = flush_count_q;
        if (flush_inc && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            sb_valid_q    <= '0;
            sb_waddr_q[0] <= '0;
            sb_waddr_q[1] <= '0;
            sb_waddr_q[2] <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sb_valid_q    <= sb_valid_d;
            sb_waddr_q[0] <= sb_waddr_d[0];
            sb_waddr_q[1] <= sb_waddr_d[1];
            sb_waddr_q[2] <= sb_waddr_d[2];
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// checked against a per-register last-write-cycle model.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_raddr1, id_raddr2, id_waddr;
    logic        id_use1, id_use2, id_wen;
    logic        ex_branch_taken;
    logic        pc_en, ifid_en, idex_bubble, flush_if;
    logic [1:0]  state;
    logic [15:0] stall_count, flush_count;
    logic        s_pc_en, s_ifid_en, s_idex_bubble, s_flush_if;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_count, s_flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycle number at which each register's producer issued
    longint last_wr [32];
    longint cyc;
    int     m_state;
    int     m_stall, m_flush;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.ASIZE(5), .CSIZE(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .id_use1(id_use1), .id_use2(id_use2),
        .id_wen(id_wen), .id_waddr(id_waddr),
        .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_bubble(idex_bubble), .flush_if(flush_if),
        .state(state), .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_stall_ctrl #(.ASIZE(5), .CSIZE(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .id_use1(id_use1), .id_use2(id_use2),
        .id_wen(id_wen), .id_waddr(id_waddr),
        .ex_branch_taken(ex_branch_taken),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_bubble(s_idex_bubble),
        .flush_if(s_flush_if), .state(s_state),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic drive(input logic v, input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2,
                         input logic w, input logic [4:0] wa, input logic br);
        id_valid = v; id_raddr1 = a1; id_use1 = u1; id_raddr2 = a2; id_use2 = u2;
        id_wen = w; id_waddr = wa; ex_branch_taken = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        foreach (last_wr[i]) last_wr[i] = -100;
        cyc = 0; m_state = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic bit m_reads_inflight(input logic u, input logic [4:0] a);
        return u && (a != 5'd0) && ((cyc - last_wr[a]) <= 3);
    endfunction

    task automatic test_reset();
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1);
        rst = 1'b1;
        #3;
        n_checks++;
        if ({pc_en, ifid_en, idex_bubble, flush_if} !== 4'b1100) begin
            n_fail++; $display("FAIL reset_outputs got %b want 1100",
                               {pc_en, ifid_en, idex_bubble, flush_if});
        end
        n_checks++;
        if (state !== 2'd0 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_state got st=%0d sc=%0d fc=%0d want 0 0 0",
                               state, stall_count, flush_count);
        end
        tick();
        idle();
        rst = 1'b0;
        #3;
        n_checks++;
        if ({pc_en, ifid_en, idex_bubble, flush_if} !== 4'b1100) begin
            n_fail++; $display("FAIL post_reset_outputs got %b want 1100",
                               {pc_en, ifid_en, idex_bubble, flush_if});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #3;
            n_checks++;
            if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_bubble !== 1'b1 || flush_if !== 1'b0) begin
                n_fail++; $display("FAIL b2b_stall%0d got %b want 0010", k,
                                   {pc_en, ifid_en, idex_bubble, flush_if});
            end
            tick();
            n_checks++;
            if (state !== 2'd1) begin
                n_fail++; $display("FAIL b2b_state%0d got %0d want 1", k, state);
            end
        end
        #3;
        n_checks++;
        if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin
            n_fail++; $display("FAIL b2b_issue got pc_en=%b bubble=%b want 1 0", pc_en, idex_bubble);
        end
        tick();
        n_checks++;
        if (state !== 2'd0 || stall_count !== 16'd3) begin
            n_fail++; $display("FAIL b2b_end got st=%0d sc=%0d want 0 3", state, stall_count);
        end
        idle();
    endtask

    task automatic test_distance();
        int st;
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        st = 0;
        for (int k = 0; k < 6; k++) begin
            #3;
            if (pc_en) break;
            st++;
            tick();
        end
        tick();
        n_checks++;
        if (st !== 2) begin
            n_fail++; $display("FAIL dist2_stalls got %0d want 2", st);
        end
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
            tick();
        end
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        #3;
        n_checks++;
        if (pc_en !== 1'b1 || stall_count !== 16'd0) begin
            n_fail++; $display("FAIL dist4 got pc_en=%b sc=%0d want 1 0", pc_en, stall_count);
        end
        tick();
        idle();
    endtask

    task automatic test_r0_unused();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0);
        #3;
        n_checks++;
        if (pc_en !== 1'b1) begin
            n_fail++; $display("FAIL r0_dest got pc_en=%b want 1", pc_en);
        end
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
        #3;
        n_checks++;
        if (pc_en !== 1'b1 || stall_count !== 16'd0) begin
            n_fail++; $display("FAIL unused_src got pc_en=%b sc=%0d want 1 0", pc_en, stall_count);
        end
        tick();
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #3;
            n_checks++;
            if ({pc_en, ifid_en, idex_bubble, flush_if} !== 4'b1111) begin
                n_fail++; $display("FAIL branch_out%0d got %b want 1111", k,
                                   {pc_en, ifid_en, idex_bubble, flush_if});
            end
            tick();
            n_checks++;
            if (state !== ((k == 0) ? 2'd2 : 2'd0)) begin
                n_fail++; $display("FAIL branch_state%0d got %0d want %0d", k, state,
                                   (k == 0) ? 2 : 0);
            end
            drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0);
        end
        drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
        #3;
        n_checks++;
        if (pc_en !== 1'b1 || flush_count !== 16'd1) begin
            n_fail++; $display("FAIL branch_squash got pc_en=%b fc=%0d want 1 1", pc_en, flush_count);
        end
        tick();
        idle();
    endtask

    task automatic test_branch_in_stall();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        ex_branch_taken = 1'b1;
        #3;
        n_checks++;
        if (pc_en !== 1'b1 || flush_if !== 1'b1) begin
            n_fail++; $display("FAIL stall_branch_out got pc_en=%b flush_if=%b want 1 1",
                               pc_en, flush_if);
        end
        tick();
        n_checks++;
        if (state !== 2'd2 || stall_count !== 16'd1 || flush_count !== 16'd1) begin
            n_fail++; $display("FAIL stall_branch got st=%0d sc=%0d fc=%0d want 2 1 1",
                               state, stall_count, flush_count);
        end
        tick();
        n_checks++;
        if (state !== 2'd0 || flush_count !== 16'd1) begin
            n_fail++; $display("FAIL flush_ignores_branch got st=%0d fc=%0d want 0 1",
                               state, flush_count);
        end
        idle();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (state !== 2'd0 || flush_count !== 16'd0 || flush_if !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_flush got st=%0d fc=%0d flush_if=%b want 0 0 0",
                               state, flush_count, flush_if);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({pc_en, ifid_en, idex_bubble, flush_if} !== 4'b1100) begin
            n_fail++; $display("FAIL rst_flush_release got %b want 1100",
                               {pc_en, ifid_en, idex_bubble, flush_if});
        end
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (state !== 2'd0 || stall_count !== 16'd0) begin
            n_fail++; $display("FAIL rst_mid_stall got st=%0d sc=%0d want 0 0", state, stall_count);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin
            n_fail++; $display("FAIL rst_stall_residual got pc_en=%b bubble=%b want 1 0",
                               pc_en, idex_bubble);
        end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
            tick();
            drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
            for (int k = 0; k < 4; k++) tick();
        end
        n_checks++;
        if (s_stall_count !== 2'd3 || stall_count !== 16'd6) begin
            n_fail++; $display("FAIL saturation got sat=%0d wide=%0d want 3 6",
                               s_stall_count, stall_count);
        end
        idle();
    endtask

    task automatic test_random();
        bit br, hz, flushing;
        logic [3:0] exp_out;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
            br       = ex_branch_taken && (m_state != 2);
            hz       = id_valid && (m_reads_inflight(id_use1, id_raddr1) ||
                                    m_reads_inflight(id_use2, id_raddr2));
            flushing = (m_state == 2) || br;
            exp_out  = flushing ? 4'b1111 : (hz ? 4'b0010 : 4'b1100);
            #3;
            n_checks++;
            if ({pc_en, ifid_en, idex_bubble, flush_if} !== exp_out) begin
                n_fail++; $display("FAIL rand_out cyc=%0d got %b want %b", cyc,
                                   {pc_en, ifid_en, idex_bubble, flush_if}, exp_out);
            end
            if (flushing) begin
                if (br) m_flush++;
                m_state = br ? 2 : 0;
            end else if (hz) begin
                m_stall++;
                m_state = 1;
            end else begin
                m_state = 0;
                if (id_valid && id_wen) last_wr[id_waddr] = cyc;
            end
            cyc++;
            tick();
            n_checks++;
            if (state !== 2'(m_state) || stall_count !== 16'(m_stall) ||
                flush_count !== 16'(m_flush)) begin
                n_fail++; $display("FAIL rand_state cyc=%0d got st=%0d sc=%0d fc=%0d want %0d %0d %0d",
                                   cyc, state, stall_count, flush_count, m_state, m_stall, m_flush);
            end
            n_checks++;
            if (s_stall_count !== 2'((m_stall > 3) ? 3 : m_stall) ||
                s_flush_count !== 2'((m_flush > 3) ? 3 : m_flush)) begin
                n_fail++; $display("FAIL rand_sat cyc=%0d got sc=%0d fc=%0d", cyc,
                                   s_stall_count, s_flush_count);
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_distance();
        test_r0_unused();
        test_branch();
        test_branch_in_stall();
        test_reset_mid_op();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
